// File: rtl/four_phase_fifo.sv
// Clocked FIFO between a four-phase bundled-data producer and consumer.
// Incoming in_req/out_ack are synchronised so either neighbour may be self-timed.
module four_phase_fifo #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_req,
    output logic                       in_ack,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_req,
    input  logic                       out_ack,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_t;

    in_state_t        r_in_state, w_in_next;
    out_state_t       r_out_state, w_out_next;
    logic             w_req_s, w_ack_s;
    logic             w_wr_en, w_rd_en, w_load, w_spurious;
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [LW-1:0]    r_level, w_level_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_out_data;
    logic             r_in_ack, r_out_req, r_full, r_empty, r_proto_err;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_req_s = in_req;
            assign w_ack_s = out_ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_req_sync, r_ack_sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_req_sync <= '0;
                    r_ack_sync <= '0;
                end else begin
                    r_req_sync[0] <= in_req;
                    r_ack_sync[0] <= out_ack;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_req_sync[i] <= r_req_sync[i-1];
                        r_ack_sync[i] <= r_ack_sync[i-1];
                    end
                end
            end
            assign w_req_s = r_req_sync[SYNC_STAGES-1];
            assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Input side: registered full gates the write, so a same-edge read unblocks it one cycle later.
    always_comb begin
        w_in_next = r_in_state;
        w_wr_en   = 1'b0;
        if (r_in_state == IN_IDLE) begin
            if (w_req_s && !r_full) begin
                w_wr_en   = 1'b1;
                w_in_next = IN_ACK;
            end
        end else if (!w_req_s) begin
            w_in_next = IN_IDLE;
        end
    end

    always_comb begin
        w_out_next = r_out_state;
        w_load     = 1'b0;
        w_rd_en    = 1'b0;
        w_spurious = 1'b0;
        case (r_out_state)
            OUT_IDLE: begin
                if (w_ack_s) begin
                    w_spurious = !r_out_req;
                end else if (!r_empty) begin
                    w_load     = 1'b1;
                    w_out_next = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (w_ack_s) begin
                    w_rd_en    = 1'b1;
                    w_out_next = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!w_ack_s) w_out_next = OUT_IDLE;
            end
            default: w_out_next = OUT_IDLE;
        endcase
    end

    always_comb begin
        case ({w_wr_en, w_rd_en})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_IDLE;
            r_in_ack    <= 1'b0;
            r_out_req   <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_proto_err <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_in_state  <= w_in_next;
            r_out_state <= w_out_next;
            r_in_ack    <= (w_in_next == IN_ACK);
            r_out_req   <= (w_out_next == OUT_REQ);
            r_level     <= w_level_next;
            r_full      <= (w_level_next == LW'(DEPTH));
            r_empty     <= (w_level_next == '0);
            if (w_wr_en) r_wptr <= r_wptr + AW'(1);
            if (w_rd_en) r_rptr <= r_rptr + AW'(1);
            if (w_load) r_out_data <= r_mem[r_rptr];
            if (w_spurious) r_proto_err <= 1'b1;
        end
    end

    // Storage holds data only; occupancy tracking makes stale entries harmless after reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr] <= in_data;
    end

    assign in_ack    = r_in_ack;
    assign out_req   = r_out_req;
    assign out_data  = r_out_data;
    assign level     = r_level;
    assign full      = r_full;
    assign empty     = r_empty;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_four_phase_fifo.sv
// Directed self-checking bench for four_phase_fifo (WIDTH=16, DEPTH=4, SYNC_STAGES=2).
module tb_four_phase_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_req = 1'b0;
    logic        in_ack;
    logic [15:0] in_data = '0;
    logic        out_req;
    logic        out_ack = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  level;
    logic        full, empty, proto_err;

    int n_checks = 0;
    int n_errors = 0;
    int max_level = 0;
    logic mon_en = 1'b0;

    four_phase_fifo #(.WIDTH(16), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .level(level), .full(full), .empty(empty), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && int'(level) > max_level) max_level = int'(level);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_in_ack(input logic v, input string tag);
        for (int i = 0; i < 50 && in_ack !== v; i++) @(negedge clk);
        chk_eq(tag, {31'd0, in_ack}, {31'd0, v});
    endtask

    task automatic wait_out_req(input logic v, input string tag);
        for (int i = 0; i < 50 && out_req !== v; i++) @(negedge clk);
        chk_eq(tag, {31'd0, out_req}, {31'd0, v});
    endtask

    task automatic send(input logic [15:0] d);
        in_data = d;
        in_req  = 1'b1;
        wait_in_ack(1'b1, "send_ack");
        in_req  = 1'b0;
        wait_in_ack(1'b0, "send_rel");
    endtask

    task automatic recv(input logic [15:0] exp, input string tag);
        wait_out_req(1'b1, "recv_req");
        chk_eq(tag, {16'd0, out_data}, {16'd0, exp});
        out_ack = 1'b1;
        wait_out_req(1'b0, "recv_drop");
        out_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // Reset state
        repeat (3) @(negedge clk);
        chk_eq("rst_in_ack", {31'd0, in_ack}, 32'd0);
        chk_eq("rst_out_req", {31'd0, out_req}, 32'd0);
        chk_eq("rst_out_data", {16'd0, out_data}, 32'd0);
        chk_eq("rst_level", {29'd0, level}, 32'd0);
        chk_eq("rst_empty", {31'd0, empty}, 32'd1);
        chk_eq("rst_full", {31'd0, full}, 32'd0);
        chk_eq("rst_proto", {31'd0, proto_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single transfer, latency checks
        in_data = 16'h1234;
        in_req  = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("t1_ack_early", {31'd0, in_ack}, 32'd0);
        @(negedge clk);
        chk_eq("t1_ack_rise", {31'd0, in_ack}, 32'd1);
        chk_eq("t1_req_early", {31'd0, out_req}, 32'd0);
        chk_eq("t1_level1", {29'd0, level}, 32'd1);
        @(negedge clk);
        chk_eq("t1_req_rise", {31'd0, out_req}, 32'd1);
        chk_eq("t1_data", {16'd0, out_data}, 32'h1234);
        in_req  = 1'b0;
        out_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("t1_req_hold", {31'd0, out_req}, 32'd1);
        @(negedge clk);
        chk_eq("t1_req_drop", {31'd0, out_req}, 32'd0);
        chk_eq("t1_level0", {29'd0, level}, 32'd0);
        chk_eq("t1_ack_drop", {31'd0, in_ack}, 32'd0);
        out_ack = 1'b0;
        repeat (4) @(negedge clk);

        // 2: fill and backpressure
        for (int i = 1; i <= 4; i++) send(16'(i));
        chk_eq("t2_full", {31'd0, full}, 32'd1);
        chk_eq("t2_level4", {29'd0, level}, 32'd4);
        in_data = 16'h0005;
        in_req  = 1'b1;
        repeat (8) @(negedge clk);
        chk_eq("t2_blocked", {31'd0, in_ack}, 32'd0);
        recv(16'h0001, "t2_first");
        wait_in_ack(1'b1, "t2_unblock");
        in_req = 1'b0;
        wait_in_ack(1'b0, "t2_rel");
        chk_eq("t2_level_refill", {29'd0, level}, 32'd4);
        for (int i = 2; i <= 5; i++) recv(16'(i), "t2_drain");
        repeat (4) @(negedge clk);
        chk_eq("t2_empty", {31'd0, empty}, 32'd1);

        // 3: delayed consumer ack
        send(16'hABCD);
        wait_out_req(1'b1, "t3_req");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_eq("t3_req_stable", {31'd0, out_req}, 32'd1);
            chk_eq("t3_data_stable", {16'd0, out_data}, 32'hABCD);
        end
        out_ack = 1'b1;
        cnt = 0;
        while (out_req === 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk_eq("t3_drop_lat", {31'd0, (cnt <= 3)}, 32'd1);
        out_ack = 1'b0;
        repeat (4) @(negedge clk);

        // 4: wrap-around with concurrent consumer
        max_level = 0;
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(16'h0A00 + 16'(i));
            end
            begin
                for (int j = 0; j < 10; j++) recv(16'h0A00 + 16'(j), "t4_order");
            end
        join
        mon_en = 1'b0;
        chk_eq("t4_max_level", {31'd0, (max_level <= 4)}, 32'd1);
        repeat (4) @(negedge clk);
        chk_eq("t4_empty", {31'd0, empty}, 32'd1);

        // 5: spurious ack on an empty FIFO
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk_eq("t5_proto", {31'd0, proto_err}, 32'd1);
        chk_eq("t5_level", {29'd0, level}, 32'd0);
        chk_eq("t5_out_req", {31'd0, out_req}, 32'd0);
        send(16'h5555);
        recv(16'h5555, "t5_data");
        repeat (4) @(negedge clk);
        chk_eq("t5_proto_sticky", {31'd0, proto_err}, 32'd1);

        // 6: reset with words buffered and out_req high
        for (int i = 0; i < 3; i++) send(16'h0B00 + 16'(i));
        chk_eq("t6_level3", {29'd0, level}, 32'd3);
        chk_eq("t6_req_pre", {31'd0, out_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("t6_out_req", {31'd0, out_req}, 32'd0);
        chk_eq("t6_in_ack", {31'd0, in_ack}, 32'd0);
        chk_eq("t6_level", {29'd0, level}, 32'd0);
        chk_eq("t6_empty", {31'd0, empty}, 32'd1);
        chk_eq("t6_proto", {31'd0, proto_err}, 32'd0);
        repeat (3) @(negedge clk);
        send(16'h7777);
        recv(16'h7777, "t6_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
